data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of data_memory. Port A is the CPU
//  load/store path, port B the loader/DMA path (program/data preload, debug peek).
//  Grants one access per cycle by round-robin, supports locked sequences
//  (read-modify-write, bursts) with a starvation bound, range-checks addresses,
//  and returns registered read data. Drives data_memory's MemRead/MemWrite,
//  mem_address and write_data; samples its read_data.
// PARAMETERS
//  DEPTH     256  data memory words; valid word addresses are 0..DEPTH-1
//  MAX_LOCK  8    max consecutive granted cycles for one locked owner (>=1)
// PORTS
//  clk         in   1   system clock, all state changes on posedge
//  reset       in   1   synchronous, active-high reset
//  a_req       in   1   A access request; hold with fields stable until a_gnt
//  a_we        in   1   A: 1=write, 0=read
//  a_lock      in   1   A: keep ownership after this grant
//  a_addr      in   32  A word address
//  a_wdata     in   32  A write data
//  a_gnt       out  1   A request accepted this cycle (combinational)
//  a_rvalid    out  1   A read/error response valid (registered)
//  a_rdata     out  32  A read data (registered)
//  a_err       out  1   A response is out-of-range error (registered, with a_rvalid)
//  b_*         same set as a_* for requester B
//  mem_address out  32  to data_memory, granted port's address
//  write_data  out  32  to data_memory, granted port's wdata
//  MemRead     out  1   to data_memory, granted in-range read
//  MemWrite    out  1   to data_memory, granted in-range write
//  read_data   in   32  from data_memory, valid in the cycle MemRead=1
// BEHAVIOUR
//  Reset (sync, while reset=1 and first cycle after): state=IDLE, rr_last=B (A wins
//   first tie), lock_cnt=0, a/b_rvalid=0, a/b_rdata=0, a/b_err=0; a/b_gnt, MemRead,
//   MemWrite forced 0 while reset=1; mem_address/write_data=0.
//  Grant (combinational from state, rr_last, req): at most one gnt per cycle.
//   IDLE: one req -> that port; both -> port != rr_last; none -> no grant.
//   OWN_A: only A may be granted; b_gnt=0. OWN_B symmetric.
//  Access: in the grant cycle mux winner's addr/wdata onto mem_address/write_data;
//   addr<DEPTH: MemWrite=we, MemRead=!we. addr>=DEPTH: MemRead=MemWrite=0, no write.
//   No grant: MemRead=MemWrite=0, mem_address/write_data hold last value.
//  Response (latency 1): granted read or any out-of-range access -> next cycle
//   x_rvalid=1 for exactly one cycle; x_rdata=read_data (0 on error); x_err=1 on
//   range error. In-range writes produce no response. rdata holds between responses.
//  FSM (updated at posedge, rr_last=winner on every grant):
//   IDLE  -> OWN_x  if x granted with x_lock=1 and MAX_LOCK>1; lock_cnt=1
//   OWN_x -> OWN_x  on x grant with x_lock=1 and lock_cnt+1<MAX_LOCK; lock_cnt++
//   OWN_x -> IDLE   on x grant with x_lock=0, x_req=0 (release), or lock_cnt+1
//                   reaching MAX_LOCK (forced release); lock_cnt=0
//   After forced release rr_last=x, so a pending other port wins next cycle.
//  Simultaneous: both req in IDLE -> RR winner only; loser holds req, served next
//   free cycle. Lock asserted by the losing port is ignored until it is granted.
//  Reset mid-sequence: ownership, lock_cnt and pending response dropped; no
//   MemWrite during reset; requesters must re-issue.
//  Widths: range check is unsigned 32-bit compare against DEPTH.
// TESTING
//  1 Reset, then A write addr 5 data 0xDEADBEEF, A read addr 5 -> MemWrite 1 cycle,
//    a_rvalid next cycle after read grant, a_rdata=0xDEADBEEF, a_err=0.
//  2 A and B req reads same cycle after reset, held -> cycle0 a_gnt, cycle1 b_gnt;
//    repeat -> continues A,B alternation; no cycle with both gnt.
//  3 A lock=1 for 3 grants then lock=0, B req throughout -> A granted 4 consecutive
//    cycles, b_gnt=0 throughout, B granted on 5th cycle.
//  4 MAX_LOCK=8, A lock held forever, B req -> A granted 8 cycles, B granted cycle 9.
//  5 B read addr 256 (DEPTH=256) -> b_gnt, MemRead=0, next cycle b_rvalid=1,
//    b_err=1, b_rdata=0; B write addr 0x1000 -> memory unchanged, b_err response.
//  6 A in OWN_A (lock) and reset pulsed 1 cycle -> all outputs reset values;
//    next B req granted immediately, no stale a_rvalid.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter_if
// Brief    : One requester port of the data-memory arbiter: request fields,
//            combinational grant and registered read/error response.
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_arbiter_if;
    logic        req;
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    // Requester side drives the request and observes grant/response
    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    // Arbiter side observes the request and drives grant/response
    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Two-port round-robin arbiter in front of data_memory. Port a is
//            the CPU load/store path, port b the loader/DMA path. Supports
//            locked ownership with a starvation bound, range-checks word
//            addresses and returns registered read data / error responses.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,
    data_mem_arbiter_if.slave a,
    data_mem_arbiter_if.slave b,
    output logic [31:0]       mem_address,
    output logic [31:0]       write_data,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [31:0]       read_data
);

    localparam int unsigned c_cnt_w = $clog2(MAX_LOCK + 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_own_a = 2'd1;
    localparam logic [1:0] c_st_own_b = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_lock_cnt;
    logic [c_cnt_w-1:0] w_lock_cnt_nxt;
    logic [c_cnt_w-1:0] w_lock_cnt_inc;
    logic               r_rr_last;      // 1 = b won the last grant
    logic               w_gnt_a;
    logic               w_gnt_b;
    logic               w_gnt;
    logic               w_we;
    logic               w_lock;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;
    logic               w_in_range;
    logic               w_resp;
    logic               w_lock_keep;
    logic [31:0]        r_addr_hold;
    logic [31:0]        r_wdata_hold;
    logic               r_a_rvalid;
    logic               r_a_err;
    logic [31:0]        r_a_rdata;
    logic               r_b_rvalid;
    logic               r_b_err;
    logic [31:0]        r_b_rdata;

    // Grant selection: owner-only while locked, round-robin on a tie when idle
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!reset) begin
            case (r_state)
                c_st_idle: begin
                    if (a.req && b.req) begin
                        w_gnt_a = r_rr_last;
                        w_gnt_b = !r_rr_last;
                    end else begin
                        w_gnt_a = a.req;
                        w_gnt_b = b.req;
                    end
                end
                c_st_own_a: w_gnt_a = a.req;
                c_st_own_b: w_gnt_b = b.req;
                default: begin
                    w_gnt_a = 1'b0;
                    w_gnt_b = 1'b0;
                end
            endcase
        end
    end

    assign w_gnt      = w_gnt_a | w_gnt_b;
    assign w_we       = w_gnt_a ? a.we    : b.we;
    assign w_lock     = w_gnt_a ? a.lock  : b.lock;
    assign w_addr     = w_gnt_a ? a.addr  : b.addr;
    assign w_wdata    = w_gnt_a ? a.wdata : b.wdata;
    assign w_in_range = (w_addr < DEPTH);
    // Reads and any out-of-range access return a response; good writes do not
    assign w_resp     = !w_we || !w_in_range;

    assign MemRead     = w_gnt && w_in_range && !w_we;
    assign MemWrite    = w_gnt && w_in_range && w_we;
    assign mem_address = w_gnt ? w_addr  : r_addr_hold;
    assign write_data  = w_gnt ? w_wdata : r_wdata_hold;

    assign a.gnt    = w_gnt_a;
    assign b.gnt    = w_gnt_b;
    assign a.rvalid = r_a_rvalid;
    assign a.err    = r_a_err;
    assign a.rdata  = r_a_rdata;
    assign b.rvalid = r_b_rvalid;
    assign b.err    = r_b_err;
    assign b.rdata  = r_b_rdata;

    assign w_lock_cnt_inc = r_lock_cnt + c_cnt_w'(1);
    // Owner keeps the bus only while it asks to and the run is below the bound
    assign w_lock_keep    = w_lock && (32'(w_lock_cnt_inc) < MAX_LOCK);

    // Ownership next-state and lock run counter
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            c_st_idle: begin
                if (w_gnt && w_lock && (MAX_LOCK > 1)) begin
                    w_state_nxt    = w_gnt_a ? c_st_own_a : c_st_own_b;
                    w_lock_cnt_nxt = c_cnt_w'(1);
                end
            end
            c_st_own_a, c_st_own_b: begin
                if (w_gnt && w_lock_keep) begin
                    w_lock_cnt_nxt = w_lock_cnt_inc;
                end else begin
                    // Voluntary release, dropped request, or forced release
                    w_state_nxt    = c_st_idle;
                    w_lock_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = c_st_idle;
                w_lock_cnt_nxt = '0;
            end
        endcase
    end

    // Ownership state, lock counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_lock_cnt <= '0;
            r_rr_last  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            if (w_gnt) begin
                r_rr_last <= w_gnt_b;
            end
        end
    end

    // Held bus values and one-cycle-latency responses per port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
            r_a_rvalid   <= 1'b0;
            r_a_err      <= 1'b0;
            r_a_rdata    <= '0;
            r_b_rvalid   <= 1'b0;
            r_b_err      <= 1'b0;
            r_b_rdata    <= '0;
        end else begin
            if (w_gnt) begin
                r_addr_hold  <= w_addr;
                r_wdata_hold <= w_wdata;
            end
            r_a_rvalid <= w_gnt_a && w_resp;
            r_a_err    <= w_gnt_a && !w_in_range;
            if (w_gnt_a && w_resp) begin
                r_a_rdata <= w_in_range ? read_data : 32'd0;
            end
            r_b_rvalid <= w_gnt_b && w_resp;
            r_b_err    <= w_gnt_b && !w_in_range;
            if (w_gnt_b && w_resp) begin
                r_b_rdata <= w_in_range ? read_data : 32'd0;
            end
        end
    end

endmodule
`default_nettype wire
